wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 121 ++++++++++++
 tb/tb_wb_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Pipeline write-back stage: holds the MEM instruction for one cycle and extracts load data.
// It drives the register-file write port and counts retired instructions.
module wb_stage #(
   parameter int unsigned data_size = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 Istall,
   input  logic                 Dstall,
   input  logic                 wfi_stall,
   input  logic                 mem_valid,
   input  logic [4:0]           mem_rd_addr,
   input  logic                 mem_rf_write,
   input  logic                 mem_to_reg,
   input  logic [2:0]           mem_funct3,
   input  logic [data_size-1:0] mem_alu_result,
   input  logic [data_size-1:0] mem_load_data,
   output logic [4:0]           write_addr,
   output logic [data_size-1:0] write_data,
   output logic                 RF_write,
   output logic                 wb_valid,
   output logic                 load_misalign,
   output logic [63:0]          instret
);

   localparam int unsigned RegW = 5;
   localparam int unsigned CntW = 64;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic                 stall;
   logic                 valid_q;
   logic [RegW-1:0]      rd_q;
   logic                 rf_write_q;
   logic                 to_reg_q;
   logic [2:0]           funct3_q;
   logic [data_size-1:0] alu_q;
   logic [data_size-1:0] load_q;
   logic [CntW-1:0]      instret_q;
   logic [CntW-1:0]      instret_d;

   logic [1:0]           off;
   logic [4:0]           byte_lsb;
   logic [4:0]           half_lsb;
   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;
   logic [data_size-1:0] ext_data;
   logic                 bad;
   logic                 bad_load;
   logic                 retire;

   assign stall = Istall | Dstall | wfi_stall;

   // WB pipeline registers; the whole stage freezes while any stall is requested
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         rd_q       <= '0;
         rf_write_q <= 1'b0;
         to_reg_q   <= 1'b0;
         funct3_q   <= '0;
         alu_q      <= '0;
         load_q     <= '0;
         instret_q  <= '0;
      end else if (!stall) begin
         valid_q    <= mem_valid;
         rd_q       <= mem_rd_addr;
         rf_write_q <= mem_rf_write;
         to_reg_q   <= mem_to_reg;
         funct3_q   <= mem_funct3;
         alu_q      <= mem_alu_result;
         load_q     <= mem_load_data;
         instret_q  <= instret_d;
      end
   end

   assign off      = alu_q[1:0];
   assign byte_lsb = {off, 3'b000};
   assign half_lsb = {off[1], 4'b0000};
   assign byte_sel = load_q[byte_lsb +: 8];
   assign half_sel = load_q[half_lsb +: 16];

   // Load extraction and legality by funct3 and byte offset
   always_comb begin
      ext_data = '0;
      bad      = 1'b0;
      case (funct3_q)
         F3_LB:  ext_data = {{(data_size-8){byte_sel[7]}}, byte_sel};
         F3_LH: begin
            ext_data = {{(data_size-16){half_sel[15]}}, half_sel};
            bad      = off[0];
         end
         F3_LW: begin
            ext_data = load_q;
            bad      = (off != 2'b00);
         end
         F3_LBU: ext_data = {{(data_size-8){1'b0}}, byte_sel};
         F3_LHU: begin
            ext_data = {{(data_size-16){1'b0}}, half_sel};
            bad      = off[0];
         end
         default: bad = 1'b1;
      endcase
   end

   assign bad_load = to_reg_q & bad;
   assign retire   = valid_q & ~bad_load;
   assign instret_d = instret_q + CntW'(retire);

   assign wb_valid      = valid_q;
   assign write_addr    = rd_q;
   assign write_data    = bad_load ? '0 : (to_reg_q ? ext_data : alu_q);
   assign RF_write      = valid_q & rf_write_q & (rd_q != '0) & ~bad_load & ~stall;
   assign load_misalign = valid_q & bad_load & ~stall;
   assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU, loads, misalign, stalls, x0/bubbles, reset.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        Istall, Dstall, wfi_stall;
   logic        mem_valid;
   logic [4:0]  mem_rd_addr;
   logic        mem_rf_write;
   logic        mem_to_reg;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_data;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        RF_write;
   logic        wb_valid;
   logic        load_misalign;
   logic [63:0] instret;

   int unsigned compared;
   int unsigned mismatched;
   logic [63:0] exp_ir;

   wb_stage #(.data_size(32)) dut (
      .clk(clk), .rst(rst),
      .Istall(Istall), .Dstall(Dstall), .wfi_stall(wfi_stall),
      .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr), .mem_rf_write(mem_rf_write),
      .mem_to_reg(mem_to_reg), .mem_funct3(mem_funct3),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .write_addr(write_addr), .write_data(write_data), .RF_write(RF_write),
      .wb_valid(wb_valid), .load_misalign(load_misalign), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic [4:0] rd, input logic rfw,
                           input logic tr, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] ld);
      mem_valid = v; mem_rd_addr = rd; mem_rf_write = rfw; mem_to_reg = tr;
      mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld;
   endtask

   task automatic test_reset();
      #1;
      compared++;
      if (wb_valid !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0 ||
          RF_write !== 1'b0 || load_misalign !== 1'b0 || instret !== 64'd0) begin
         mismatched++;
         $display("FAIL reset_outputs got v=%b a=%0d d=%h w=%b m=%b ir=%0d want all zero",
                  wb_valid, write_addr, write_data, RF_write, load_misalign, instret);
      end
      step();
      rst = 1'b1;
      step();
      compared++;
      if (wb_valid !== 1'b0 || RF_write !== 1'b0 || instret !== 64'd0) begin
         mismatched++;
         $display("FAIL reset_idle got v=%b w=%b ir=%0d want 0/0/0", wb_valid, RF_write, instret);
      end
   endtask

   task automatic test_alu();
      drive_op(1'b1, 5'd5, 1'b1, 1'b0, 3'b000, 32'h1234_5678, 32'h0);
      step();
      compared++;
      if (RF_write !== 1'b1 || write_addr !== 5'd5 || write_data !== 32'h1234_5678 ||
          wb_valid !== 1'b1 || instret !== 64'd0) begin
         mismatched++;
         $display("FAIL alu_wb got w=%b a=%0d d=%h v=%b ir=%0d want 1/5/12345678/1/0",
                  RF_write, write_addr, write_data, wb_valid, instret);
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      compared++;
      if (instret !== 64'd1 || RF_write !== 1'b0 || wb_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL alu_retire got ir=%0d w=%b v=%b want 1/0/0", instret, RF_write, wb_valid);
      end
      exp_ir = 64'd1;
   endtask

   task automatic test_loads();
      logic [2:0]  f3  [5];
      logic [1:0]  off [5];
      logic [31:0] exp [5];
      f3[0] = 3'b000; off[0] = 2'd3; exp[0] = 32'hFFFF_FF80;
      f3[1] = 3'b100; off[1] = 2'd3; exp[1] = 32'h0000_0080;
      f3[2] = 3'b001; off[2] = 2'd2; exp[2] = 32'hFFFF_80FF;
      f3[3] = 3'b101; off[3] = 2'd0; exp[3] = 32'h0000_7F01;
      f3[4] = 3'b010; off[4] = 2'd0; exp[4] = 32'h80FF_7F01;
      for (int i = 0; i < 5; i++) begin
         drive_op(1'b1, 5'(10 + i), 1'b1, 1'b1, f3[i], 32'h0000_1000 | 32'(off[i]), 32'h80FF_7F01);
         step();
         compared++;
         if (write_data !== exp[i] || RF_write !== 1'b1 || load_misalign !== 1'b0 ||
             write_addr !== 5'(10 + i) || instret !== exp_ir) begin
            mismatched++;
            $display("FAIL load_%0d got d=%h w=%b m=%b a=%0d ir=%0d want d=%h w=1 m=0 a=%0d ir=%0d",
                     i, write_data, RF_write, load_misalign, write_addr, instret,
                     exp[i], 10 + i, exp_ir);
         end
         exp_ir++;
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      compared++;
      if (instret !== exp_ir) begin
         mismatched++;
         $display("FAIL load_count got %0d want %0d", instret, exp_ir);
      end
   endtask

   task automatic test_misalign();
      logic [2:0]  f3  [3];
      logic [31:0] adr [3];
      f3[0] = 3'b010; adr[0] = 32'h0000_2002;
      f3[1] = 3'b001; adr[1] = 32'h0000_2001;
      f3[2] = 3'b011; adr[2] = 32'h0000_2000;
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b1, 5'd7, 1'b1, 1'b1, f3[i], adr[i], 32'h80FF_7F01);
         step();
         compared++;
         if (load_misalign !== 1'b1 || RF_write !== 1'b0 || write_data !== 32'd0 ||
             wb_valid !== 1'b1 || instret !== exp_ir) begin
            mismatched++;
            $display("FAIL misalign_%0d got m=%b w=%b d=%h v=%b ir=%0d want 1/0/0/1/%0d",
                     i, load_misalign, RF_write, write_data, wb_valid, instret, exp_ir);
         end
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      compared++;
      if (load_misalign !== 1'b0 || instret !== exp_ir) begin
         mismatched++;
         $display("FAIL misalign_after got m=%b ir=%0d want 0/%0d", load_misalign, instret, exp_ir);
      end
   endtask

   task automatic test_stall();
      drive_op(1'b1, 5'd3, 1'b1, 1'b0, 3'b000, 32'h0000_A5A5, 32'h0);
      step();
      Dstall = 1'b1;
      drive_op(1'b1, 5'd4, 1'b1, 1'b0, 3'b000, 32'h0000_0044, 32'h0);
      #1;
      compared++;
      if (RF_write !== 1'b0 || wb_valid !== 1'b1 || write_addr !== 5'd3) begin
         mismatched++;
         $display("FAIL stall_enter got w=%b v=%b a=%0d want 0/1/3", RF_write, wb_valid, write_addr);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         compared++;
         if (RF_write !== 1'b0 || write_addr !== 5'd3 || write_data !== 32'h0000_A5A5 ||
             instret !== exp_ir) begin
            mismatched++;
            $display("FAIL stall_hold_%0d got w=%b a=%0d d=%h ir=%0d want 0/3/a5a5/%0d",
                     i, RF_write, write_addr, write_data, instret, exp_ir);
         end
      end
      Dstall = 1'b0;
      #1;
      compared++;
      if (RF_write !== 1'b1 || write_addr !== 5'd3 || instret !== exp_ir) begin
         mismatched++;
         $display("FAIL stall_release got w=%b a=%0d ir=%0d want 1/3/%0d",
                  RF_write, write_addr, instret, exp_ir);
      end
      step();
      exp_ir++;
      compared++;
      if (RF_write !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'h44 || instret !== exp_ir) begin
         mismatched++;
         $display("FAIL stall_next got w=%b a=%0d d=%h ir=%0d want 1/4/44/%0d",
                  RF_write, write_addr, write_data, instret, exp_ir);
      end
      Istall = 1'b1;
      #1;
      compared++;
      if (RF_write !== 1'b0) begin
         mismatched++;
         $display("FAIL istall_gate got w=%b want 0", RF_write);
      end
      step();
      Istall = 1'b0;
      wfi_stall = 1'b1;
      #1;
      compared++;
      if (RF_write !== 1'b0 || write_addr !== 5'd4 || instret !== exp_ir) begin
         mismatched++;
         $display("FAIL wfi_gate got w=%b a=%0d ir=%0d want 0/4/%0d", RF_write, write_addr, instret, exp_ir);
      end
      step();
      wfi_stall = 1'b0;
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      exp_ir++;
      compared++;
      if (instret !== exp_ir || wb_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL stall_count got ir=%0d v=%b want %0d/0", instret, wb_valid, exp_ir);
      end
   endtask

   task automatic test_x0_bubble();
      drive_op(1'b1, 5'd0, 1'b1, 1'b0, 3'b000, 32'h0000_DEAD, 32'h0);
      step();
      compared++;
      if (RF_write !== 1'b0 || wb_valid !== 1'b1 || write_data !== 32'h0000_DEAD) begin
         mismatched++;
         $display("FAIL x0_write got w=%b v=%b d=%h want 0/1/dead", RF_write, wb_valid, write_data);
      end
      drive_op(1'b0, 5'd5, 1'b1, 1'b0, 3'b000, 32'h0000_0055, 32'h0);
      step();
      exp_ir++;
      compared++;
      if (instret !== exp_ir || wb_valid !== 1'b0 || RF_write !== 1'b0 || load_misalign !== 1'b0) begin
         mismatched++;
         $display("FAIL bubble got ir=%0d v=%b w=%b m=%b want %0d/0/0/0",
                  instret, wb_valid, RF_write, load_misalign, exp_ir);
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      compared++;
      if (instret !== exp_ir) begin
         mismatched++;
         $display("FAIL bubble_count got %0d want %0d", instret, exp_ir);
      end
   endtask

   task automatic test_reset_mid();
      drive_op(1'b1, 5'd9, 1'b1, 1'b1, 3'b010, 32'h0000_2000, 32'hCAFE_F00D);
      step();
      compared++;
      if (wb_valid !== 1'b1 || write_data !== 32'hCAFE_F00D || RF_write !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_pre got v=%b d=%h w=%b want 1/cafef00d/1", wb_valid, write_data, RF_write);
      end
      Dstall = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      compared++;
      if (wb_valid !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0 ||
          RF_write !== 1'b0 || load_misalign !== 1'b0 || instret !== 64'd0) begin
         mismatched++;
         $display("FAIL rst_async got v=%b a=%0d d=%h w=%b m=%b ir=%0d want all zero",
                  wb_valid, write_addr, write_data, RF_write, load_misalign, instret);
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      Dstall = 1'b0;
      step();
      #2;
      rst = 1'b1;
      step();
      compared++;
      if (RF_write !== 1'b0 || wb_valid !== 1'b0 || instret !== 64'd0) begin
         mismatched++;
         $display("FAIL rst_release got w=%b v=%b ir=%0d want 0/0/0", RF_write, wb_valid, instret);
      end
      drive_op(1'b1, 5'd6, 1'b1, 1'b0, 3'b000, 32'h0000_0066, 32'h0);
      step();
      compared++;
      if (RF_write !== 1'b1 || write_addr !== 5'd6 || write_data !== 32'h66) begin
         mismatched++;
         $display("FAIL rst_resume got w=%b a=%0d d=%h want 1/6/66", RF_write, write_addr, write_data);
      end
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      step();
      compared++;
      if (instret !== 64'd1) begin
         mismatched++;
         $display("FAIL rst_count got %0d want 1", instret);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      exp_ir = 64'd0;
      rst = 1'b0;
      Istall = 1'b0; Dstall = 1'b0; wfi_stall = 1'b0;
      drive_op(1'b0, 5'd0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      test_reset();
      test_alu();
      test_loads();
      test_misalign();
      test_stall();
      test_x0_bubble();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
